// File: rtl/poly_pkg.sv
// Shared types and constants for the polynomial root search block:
// controller state encoding and the operand-mux selects of the datapath.
package poly_pkg;

    // Default datapath width; all arithmetic wraps modulo 2^W.
    localparam int W_DEF = 16;

    // Controller states. One Horner step per EVAL state, then the compare.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EVAL1 = 3'd1,
        EVAL2 = 3'd2,
        EVAL3 = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_e;

    // Multiplier left operand: latched A (first Horner step) or H+B (second).
    typedef enum logic {
        MUL_A  = 1'b0,
        MUL_HB = 1'b1
    } mul_sel_e;

    // Adder right operand: B (feeds the multiplier) or C (forms the sum S).
    typedef enum logic {
        ADD_B = 1'b0,
        ADD_C = 1'b1
    } add_sel_e;

endpackage

// File: rtl/poly_root_search_if.sv
// Start/done handshake and operand bus of the root search block.
interface poly_root_search_if #(
    parameter int W = 16
) ();
    logic         inicio;
    logic [W-1:0] y;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] C;
    logic         ocupado;
    logic         pronto;
    logic         encontrado;
    logic [W-1:0] x_out;

    // Requester side: issues the start and the operands, observes the result.
    modport master (
        output inicio, y, A, B, C,
        input  ocupado, pronto, encontrado, x_out
    );

    // Search engine side.
    modport slave (
        input  inicio, y, A, B, C,
        output ocupado, pronto, encontrado, x_out
    );
endinterface

// File: rtl/poly_root_bo.sv
// Datapath of the root search: latched operands, candidate counter x,
// Horner registers H and S, one shared W x W multiplier, one shared adder,
// equality comparator, and the held result registers.
module poly_root_bo
    import poly_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int X_MAX = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic         i_ld_h,
    input  mul_sel_e     i_mul_sel,
    input  add_sel_e     i_add_sel,
    input  logic         i_ld_s,
    input  logic         i_inc_x,
    input  logic         i_found,
    input  logic         i_not_found,
    input  logic [W-1:0] i_y,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    output logic         o_match,
    output logic         o_last,
    output logic         o_encontrado,
    output logic [W-1:0] o_x_out
);

    localparam logic [W-1:0] X_LAST = W'(X_MAX);

    logic [W-1:0] r_y, r_a, r_b, r_c;
    logic [W-1:0] r_x, r_h, r_s;
    logic [W-1:0] r_x_out;
    logic         r_encontrado;

    logic [W-1:0] w_add_rhs;
    logic [W-1:0] w_sum;
    logic [W-1:0] w_mul_lhs;
    logic [W-1:0] w_prod;

    // Shared adder: H+B feeds the multiplier, H+C forms the final sum.
    assign w_add_rhs = (i_add_sel == ADD_C) ? r_c : r_b;
    assign w_sum     = r_h + w_add_rhs;

    // Shared multiplier; keeping only the low W bits is the mod 2^W wrap.
    assign w_mul_lhs = (i_mul_sel == MUL_HB) ? w_sum : r_a;
    assign w_prod    = w_mul_lhs * r_x;

    assign o_match      = (r_s == r_y);
    assign o_last       = (r_x == X_LAST);
    assign o_encontrado = r_encontrado;
    assign o_x_out      = r_x_out;

    // Capture the operands once per search so later bus changes are ignored.
    // NOTE: these are a handful of flops, not a memory, so every one is reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_y <= '0;
            r_a <= '0;
            r_b <= '0;
            r_c <= '0;
        end else if (i_start) begin
            // NOTE: non-blocking so every register samples pre-edge values.
            r_y <= i_y;
            r_a <= i_a;
            r_b <= i_b;
            r_c <= i_c;
        end
    end

    // Candidate counter: cleared on start, bumped only after a failed compare
    // that was not the last candidate, so it never wraps past X_MAX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x <= '0;
        end else if (i_start) begin
            r_x <= '0;
        end else if (i_inc_x) begin
            r_x <= r_x + W'(1);
        end
    end

    // Horner accumulators: H takes the multiplier output, S the final sum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h <= '0;
            r_s <= '0;
        end else begin
            if (i_ld_h) r_h <= w_prod;
            if (i_ld_s) r_s <= w_sum;
        end
    end

    // Result registers, held from the done pulse until the next start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_encontrado <= 1'b0;
            r_x_out      <= '0;
        end else if (i_start) begin
            r_encontrado <= 1'b0;
        end else if (i_found) begin
            r_encontrado <= 1'b1;
            r_x_out      <= r_x;
        end else if (i_not_found) begin
            r_encontrado <= 1'b0;
            r_x_out      <= X_LAST;
        end
    end

endmodule

// File: rtl/poly_root_search.sv
// Root search top: control FSM sequencing the Horner datapath over
// x = 0..X_MAX and reporting the first x where A*x^2+B*x+C == y (mod 2^W).
module poly_root_search
    import poly_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int X_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    poly_root_search_if.slave bus
);

    state_e   r_state;
    state_e   w_next;
    logic     w_start;
    logic     w_ld_h;
    mul_sel_e w_mul_sel;
    add_sel_e w_add_sel;
    logic     w_ld_s;
    logic     w_inc_x;
    logic     w_found;
    logic     w_not_found;
    logic     w_match;
    logic     w_last;

    // State register; reset aborts any search in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Next-state and datapath strobes for the current state.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_next      = r_state;
        w_start     = 1'b0;
        w_ld_h      = 1'b0;
        w_mul_sel   = MUL_A;
        w_add_sel   = ADD_B;
        w_ld_s      = 1'b0;
        w_inc_x     = 1'b0;
        w_found     = 1'b0;
        w_not_found = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.inicio) begin
                    w_start = 1'b1;
                    w_next  = EVAL1;
                end
            end
            EVAL1: begin
                w_ld_h    = 1'b1;
                w_mul_sel = MUL_A;
                w_next    = EVAL2;
            end
            EVAL2: begin
                w_ld_h    = 1'b1;
                w_mul_sel = MUL_HB;
                w_add_sel = ADD_B;
                w_next    = EVAL3;
            end
            EVAL3: begin
                w_ld_s    = 1'b1;
                w_add_sel = ADD_C;
                w_next    = CHECK;
            end
            CHECK: begin
                if (w_match) begin
                    w_found = 1'b1;
                    w_next  = DONE;
                end else if (w_last) begin
                    w_not_found = 1'b1;
                    w_next      = DONE;
                end else begin
                    w_inc_x = 1'b1;
                    w_next  = EVAL1;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Status flags are pure decodes of the registered state.
    assign bus.ocupado = (r_state == EVAL1) || (r_state == EVAL2) ||
                         (r_state == EVAL3) || (r_state == CHECK);
    assign bus.pronto  = (r_state == DONE);

    poly_root_bo #(
        .W     (W),
        .X_MAX (X_MAX)
    ) u_bo (
        .clk          (clk),
        .rst          (rst),
        .i_start      (w_start),
        .i_ld_h       (w_ld_h),
        .i_mul_sel    (w_mul_sel),
        .i_add_sel    (w_add_sel),
        .i_ld_s       (w_ld_s),
        .i_inc_x      (w_inc_x),
        .i_found      (w_found),
        .i_not_found  (w_not_found),
        .i_y          (bus.y),
        .i_a          (bus.A),
        .i_b          (bus.B),
        .i_c          (bus.C),
        .o_match      (w_match),
        .o_last       (w_last),
        .o_encontrado (bus.encontrado),
        .o_x_out      (bus.x_out)
    );

endmodule

// File: tb/tb_poly_root_search.sv
// Self-checking bench for poly_root_search: directed cases, randomized
// searches against a plain-arithmetic reference model, restart/reset cases.
module tb_poly_root_search;

    localparam int W      = 16;
    localparam int X_MAX  = 15;
    localparam int BUDGET = 200;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    poly_root_search_if #(.W(W)) bus ();

    poly_root_search #(
        .W     (W),
        .X_MAX (X_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Polynomial value mod 2^16 using wide plain arithmetic.
    function automatic logic [15:0] poly_val(input logic [15:0] a, b, c, input int n);
        longint unsigned v;
        v = 64'(a) * 64'(n) * 64'(n) + 64'(b) * 64'(n) + 64'(c);
        return v[15:0];
    endfunction

    // Reference: scan all candidates, keep the smallest matching x.
    function automatic void ref_search(input logic [15:0] ty, a, b, c,
                                       output bit f, output logic [15:0] xr,
                                       output int lat);
        f   = 1'b0;
        xr  = 16'(X_MAX);
        lat = 4 + 4 * X_MAX;
        for (int n = 0; n <= X_MAX; n++) begin
            if (!f && poly_val(a, b, c, n) == ty) begin
                f   = 1'b1;
                xr  = 16'(n);
                lat = 4 + 4 * n;
            end
        end
    endfunction

    // One search from IDLE; optionally pokes inicio and alters operands at
    // start+poke_at to show mid-search requests and bus changes are ignored.
    task automatic do_search(input string name, input logic [15:0] ty, ta, tb, tc,
                             input bit exp_f, input logic [15:0] exp_x,
                             input int exp_lat, input int poke_at);
        int lat;
        lat = -1;
        bus.y = ty; bus.A = ta; bus.B = tb; bus.C = tc;
        bus.inicio = 1'b1;
        @(posedge clk); #1;
        bus.inicio = 1'b0;
        total++;
        if (bus.ocupado !== 1'b1) begin
            bad++; $display("FAIL %s busy_after_start got=%b want=1", name, bus.ocupado);
        end
        for (int i = 1; i <= BUDGET && lat < 0; i++) begin
            if (i == poke_at) begin
                bus.inicio = 1'b1; bus.y = ~ty; bus.A = ta + 16'd1;
            end else begin
                bus.inicio = 1'b0;
            end
            @(posedge clk); #1;
            if (bus.pronto === 1'b1) lat = i;
        end
        bus.inicio = 1'b0;
        total++;
        if (lat != exp_lat) begin
            bad++; $display("FAIL %s latency got=%0d want=%0d (-1 = timeout)", name, lat, exp_lat);
        end
        total++;
        if (bus.encontrado !== exp_f) begin
            bad++; $display("FAIL %s encontrado got=%b want=%b", name, bus.encontrado, exp_f);
        end
        total++;
        if (bus.x_out !== exp_x) begin
            bad++; $display("FAIL %s x_out got=%0d want=%0d", name, bus.x_out, exp_x);
        end
        total++;
        if (bus.ocupado !== 1'b0) begin
            bad++; $display("FAIL %s busy_at_done got=%b want=0", name, bus.ocupado);
        end
        @(posedge clk); #1;
        total++;
        if (bus.pronto !== 1'b0) begin
            bad++; $display("FAIL %s pronto_width got=%b want=0", name, bus.pronto);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.inicio = 1'b0; bus.y = '0; bus.A = '0; bus.B = '0; bus.C = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.ocupado, bus.pronto, bus.encontrado, bus.x_out} !== 19'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b%b%b x=%0d want=0000", bus.ocupado,
                     bus.pronto, bus.encontrado, bus.x_out);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        do_search("t1_match_x2", 16'd10, 16'd1, 16'd2, 16'd2, 1'b1, 16'd2, 12, 0);
        do_search("t2_match_x0", 16'd2, 16'd1, 16'd2, 16'd2, 1'b1, 16'd0, 4, 0);
        do_search("t3_no_match", 16'd7, 16'd0, 16'd0, 16'd5, 1'b0, 16'd15, 64, 0);
        do_search("t4_wrap", 16'd3, 16'd0, 16'hFFFF, 16'd5, 1'b1, 16'd2, 12, 0);
    endtask

    task automatic test_ignore_restart();
        do_search("t5_restart_ignored", 16'd10, 16'd1, 16'd2, 16'd2, 1'b1, 16'd2, 12, 5);
    endtask

    task automatic test_reset_mid();
        bus.y = 16'd7; bus.A = 16'd0; bus.B = 16'd0; bus.C = 16'd5;
        bus.inicio = 1'b1;
        @(posedge clk); #1;
        bus.inicio = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        total++;
        if ({bus.ocupado, bus.pronto, bus.encontrado, bus.x_out} !== 19'd0) begin
            bad++;
            $display("FAIL t6_abort_outputs got=%b%b%b x=%0d want=0000", bus.ocupado,
                     bus.pronto, bus.encontrado, bus.x_out);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (bus.pronto !== 1'b0) begin
                bad++; $display("FAIL t6_no_pronto_in_reset got=%b want=0", bus.pronto);
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        do_search("t6_after_reset", 16'd10, 16'd1, 16'd2, 16'd2, 1'b1, 16'd2, 12, 0);
    endtask

    task automatic test_random();
        logic [15:0] ty, ta, tb, tc, ex;
        bit          ef;
        int          el;
        for (int t = 0; t < 20; t++) begin
            ta = 16'($urandom);
            tb = 16'($urandom);
            tc = 16'($urandom);
            if (t % 4 == 3) ty = 16'($urandom);
            else            ty = poly_val(ta, tb, tc, int'($urandom_range(0, 20)));
            ref_search(ty, ta, tb, tc, ef, ex, el);
            do_search($sformatf("rand%0d", t), ty, ta, tb, tc, ef, ex, el, 0);
        end
    endtask

    // inicio held high: a new search starts on every IDLE visit, so done
    // pulses recur every latency+2 edges.
    task automatic test_back_to_back();
        int pulses;
        int edge_no;
        pulses  = 0;
        edge_no = 0;
        bus.y = 16'd2; bus.A = 16'd1; bus.B = 16'd2; bus.C = 16'd2;
        bus.inicio = 1'b1;
        @(posedge clk); #1;
        while (pulses < 3 && edge_no < BUDGET) begin
            @(posedge clk); #1;
            edge_no++;
            if (bus.pronto === 1'b1) begin
                total++;
                if (edge_no != 4 + 6 * pulses) begin
                    bad++;
                    $display("FAIL b2b_pulse%0d_edge got=%0d want=%0d", pulses, edge_no,
                             4 + 6 * pulses);
                end
                total++;
                if (bus.encontrado !== 1'b1 || bus.x_out !== 16'd0) begin
                    bad++;
                    $display("FAIL b2b_pulse%0d_result got=%b/%0d want=1/0", pulses,
                             bus.encontrado, bus.x_out);
                end
                pulses++;
            end
        end
        bus.inicio = 1'b0;
        total++;
        if (pulses != 3) begin
            bad++; $display("FAIL b2b_pulse_count got=%0d want=3", pulses);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.ocupado !== 1'b0) begin
            bad++; $display("FAIL b2b_idle_after_release got=%b want=0", bus.ocupado);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_directed();
        test_ignore_restart();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
